alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
Registered, handshaked successor to the combinational ALU control decoder in the MIPS execute stage. Accepts one {ALUop, FuncCode} per transaction and decodes it to an ALUCtrl code. Emits one control beat for single-cycle ops, or a counted burst of beats for multi-cycle MULA. Sits between the ID/EX register and the ALU, and provides backpressure to issue.

Parameters:
OP_W, 4, width of ALUop and ALUCtrl
FUNC_W, 6, width of FuncCode
MULA_BEATS, 4, beats emitted for MULA (>=2)
STEP_W, 2, width of Step; must be >= clog2(MULA_BEATS)

Ports:
Clk  in  1  clock, rising edge
Reset_n  in  1  asynchronous active-low reset
InValid  in  1  request valid
InReady  out  1  block can accept request
ALUop  in  OP_W  4'b1111 = R-type (use FuncCode), else direct ALU code
FuncCode  in  FUNC_W  R-type funct field
OutValid  out  1  control beat valid
OutReady  in  1  ALU consumes beat
ALUCtrl  out  OP_W  decoded control code
Step  out  STEP_W  beat index within burst, 0-based
Last  out  1  final beat of transaction
IllegalOp  out  1  sticky illegal-funct flag (see Optional Feature)

Behaviour:
- Clock/reset: one clock (Clk); reset asynchronous, active-low (Reset_n).
- Reset values: OutValid=0, ALUCtrl=0, Step=0, Last=0, IllegalOp=0; FSM enters IDLE. InReady=1 after reset.
- Decoding when ALUop=4'b1111, by funct:
  - 000000 SLL->0011; 000010 SRL->0100; 000011 SRA->1101
  - 100000 ADD->0010; 100001 ADDU->1000; 100010 SUB->0110; 100011 SUBU->1001
  - 100100 AND->0000; 100101 OR->0001; 100110 XOR->1010; 100111 NOR->1100
  - 101010 SLT->0111; 101011 SLTU->1011; 111000 MULA->0101
  - Any other funct is illegal.
- Decoding when ALUop!=4'b1111: ALUCtrl=ALUop and FuncCode is ignored, including X/Z values. ALUop=0101 is treated as MULA.
- Handshakes:
  - Request accepted when InValid&&InReady.
  - Beat retired when OutValid&&OutReady.
  - OutValid, ALUCtrl, Step and Last hold stable while OutValid&&!OutReady.
- FSM states:
  - IDLE: OutValid=0, InReady=1. Accept -> SINGLE or MULTI; decoded code is registered and OutValid=1 on the next cycle (latency 1).
  - SINGLE: Step=0, Last=1. InReady=OutReady. On retire with a simultaneous accept, load the new request (back-to-back, zero bubble). On retire with no accept -> IDLE.
  - MULTI: ALUCtrl=0101, Step counts 0..MULA_BEATS-1, Last=1 only when Step=MULA_BEATS-1. InReady=0 except on the Last beat, where InReady=OutReady. Each retire increments Step. Retiring the Last beat behaves as in SINGLE.
- Throughput: single ops 1 per cycle sustained; MULA occupies MULA_BEATS retired beats.
- Reset mid-burst: immediate abort; outputs return to reset values; the partial burst is dropped.
- InValid with InReady=0: request is not captured; upstream holds it.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an illegal funct is still accepted and emitted as a single beat with ALUCtrl=0010, and IllegalOp is set on that cycle. IllegalOp stays set until reset.
- Undefined: an illegal funct is emitted as ADD (0010) and IllegalOp is tied to 0.

Decomposition:
- Package alu_ctrl_pkg:
  - ALUCtrl code localparams (AND..LUI, 4'b0000..4'b1110)
  - funct localparams (SLLFunc..MULAFunc)
  - R-type marker 4'b1111
  - FSM state enum {IDLE, SINGLE, MULTI}
- Sub-module alu_ctrl_decode: pure combinational {ALUop,FuncCode} -> {ALUCtrl, is_multi, illegal}, reusable by the existing decoder. The sequencing FSM and counter stay in alu_ctrl_seq.

Test Plan:
- All 13 R-type functs plus direct ALUop codes 0000,0001,0010,0110,0111,1000,1001,1010,1011,1100,1110 with FuncCode=X, OutReady=1 -> correct ALUCtrl one cycle after accept; Last=1; Step=0.
- Back-to-back ADD, SUB, OR with OutReady=1 -> three consecutive OutValid cycles (0010,0110,0001); InReady held 1.
- MULA (FuncCode=111000), MULA_BEATS=4, OutReady=1 -> 4 beats, ALUCtrl=0101, Step 0,1,2,3, Last only on Step 3; InReady=0 for first 3 beats.
- OutReady=0 for 3 cycles mid-MULA at Step=1 -> outputs frozen at Step=1; burst resumes on release with no beat lost or duplicated.
- Reset_n pulled low at Step=2 of MULA -> next cycle OutValid=0, Step=0, InReady=1; a following ADD decodes normally.
- FuncCode=111111 with ALUop=1111 -> ALUCtrl=0010. With ILLEGAL_TRAP_EN, IllegalOp=1 and sticky until reset; without it, IllegalOp=0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the registered ALU control sequencer.
package alu_ctrl_pkg;

  localparam int unsigned ALU_OP_W     = 4;
  localparam int unsigned FUNC_FIELD_W = 6;

  // ALU control codes
  localparam logic [3:0] AND  = 4'b0000;
  localparam logic [3:0] OR   = 4'b0001;
  localparam logic [3:0] ADD  = 4'b0010;
  localparam logic [3:0] SLL  = 4'b0011;
  localparam logic [3:0] SRL  = 4'b0100;
  localparam logic [3:0] MULA = 4'b0101;
  localparam logic [3:0] SUB  = 4'b0110;
  localparam logic [3:0] SLT  = 4'b0111;
  localparam logic [3:0] ADDU = 4'b1000;
  localparam logic [3:0] SUBU = 4'b1001;
  localparam logic [3:0] XOR  = 4'b1010;
  localparam logic [3:0] SLTU = 4'b1011;
  localparam logic [3:0] NOR  = 4'b1100;
  localparam logic [3:0] SRA  = 4'b1101;
  localparam logic [3:0] LUI  = 4'b1110;

  // ALUop value that selects decoding from the funct field
  localparam logic [3:0] RTYPE = 4'b1111;

  // R-type funct field values
  localparam logic [5:0] SLLFunc  = 6'b000000;
  localparam logic [5:0] SRLFunc  = 6'b000010;
  localparam logic [5:0] SRAFunc  = 6'b000011;
  localparam logic [5:0] ADDFunc  = 6'b100000;
  localparam logic [5:0] ADDUFunc = 6'b100001;
  localparam logic [5:0] SUBFunc  = 6'b100010;
  localparam logic [5:0] SUBUFunc = 6'b100011;
  localparam logic [5:0] ANDFunc  = 6'b100100;
  localparam logic [5:0] ORFunc   = 6'b100101;
  localparam logic [5:0] XORFunc  = 6'b100110;
  localparam logic [5:0] NORFunc  = 6'b100111;
  localparam logic [5:0] SLTFunc  = 6'b101010;
  localparam logic [5:0] SLTUFunc = 6'b101011;
  localparam logic [5:0] MULAFunc = 6'b111000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational {ALUop, FuncCode} -> ALU control decoder.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OP_W   = ALU_OP_W,
  parameter int unsigned FUNC_W = FUNC_FIELD_W
) (
  input  logic [OP_W-1:0]   alu_op,
  input  logic [FUNC_W-1:0] func_code,
  output logic [OP_W-1:0]   alu_ctrl,
  output logic              is_multi,
  output logic              illegal
);

  // Direct codes pass through; R-type looks up the funct field, unknown functs fall back to ADD
  always_comb begin
    alu_ctrl = OP_W'(ADD);
    illegal  = 1'b0;
    if (alu_op == OP_W'(RTYPE)) begin
      case (func_code)
        FUNC_W'(SLLFunc):  alu_ctrl = OP_W'(SLL);
        FUNC_W'(SRLFunc):  alu_ctrl = OP_W'(SRL);
        FUNC_W'(SRAFunc):  alu_ctrl = OP_W'(SRA);
        FUNC_W'(ADDFunc):  alu_ctrl = OP_W'(ADD);
        FUNC_W'(ADDUFunc): alu_ctrl = OP_W'(ADDU);
        FUNC_W'(SUBFunc):  alu_ctrl = OP_W'(SUB);
        FUNC_W'(SUBUFunc): alu_ctrl = OP_W'(SUBU);
        FUNC_W'(ANDFunc):  alu_ctrl = OP_W'(AND);
        FUNC_W'(ORFunc):   alu_ctrl = OP_W'(OR);
        FUNC_W'(XORFunc):  alu_ctrl = OP_W'(XOR);
        FUNC_W'(NORFunc):  alu_ctrl = OP_W'(NOR);
        FUNC_W'(SLTFunc):  alu_ctrl = OP_W'(SLT);
        FUNC_W'(SLTUFunc): alu_ctrl = OP_W'(SLTU);
        FUNC_W'(MULAFunc): alu_ctrl = OP_W'(MULA);
        default: begin
          alu_ctrl = OP_W'(ADD);
          illegal  = 1'b1;
        end
      endcase
    end else begin
      alu_ctrl = alu_op;
    end
    is_multi = (alu_ctrl == OP_W'(MULA));
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU control sequencer; MULA expands to a counted burst.
// Optional: define ILLEGAL_TRAP_EN to get a sticky IllegalOp flag on illegal functs.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OP_W       = ALU_OP_W,
  parameter int unsigned FUNC_W     = FUNC_FIELD_W,
  parameter int unsigned MULA_BEATS = 4,
  parameter int unsigned STEP_W     = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              InValid,
  output logic              InReady,
  input  logic [OP_W-1:0]   ALUop,
  input  logic [FUNC_W-1:0] FuncCode,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [OP_W-1:0]   ALUCtrl,
  output logic [STEP_W-1:0] Step,
  output logic              Last,
  output logic              IllegalOp
);

  state_t              state_q, state_d;
  logic [OP_W-1:0]     ctrl_q, ctrl_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                last_q, last_d;
  logic                load;
  logic                accept;
  logic                retire;
  logic [OP_W-1:0]     dec_ctrl;
  logic                dec_multi;
  logic                dec_illegal;

  alu_ctrl_decode #(
    .OP_W   (OP_W),
    .FUNC_W (FUNC_W)
  ) u_decode (
    .alu_op    (ALUop),
    .func_code (FuncCode),
    .alu_ctrl  (dec_ctrl),
    .is_multi  (dec_multi),
    .illegal   (dec_illegal)
  );

  assign accept  = InValid && InReady;
  assign retire  = OutValid && OutReady;
  assign ALUCtrl = ctrl_q;
  assign Step    = step_q;
  assign Last    = last_q;

  // State and beat registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      step_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      step_q  <= step_d;
      last_q  <= last_d;
    end
  end

  // Next state: load a new request, advance the burst, or drop back to idle
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    step_d  = step_q;
    last_d  = last_q;
    load    = 1'b0;
    case (state_q)
      IDLE: load = accept;
      SINGLE, MULTI: begin
        if (retire) begin
          if (last_q) begin
            if (accept) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              step_d  = '0;
              last_d  = 1'b0;
            end
          end else begin
            step_d = step_q + STEP_W'(1);
            last_d = (step_q == STEP_W'(MULA_BEATS - 2));
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = dec_multi ? MULTI : SINGLE;
      ctrl_d  = dec_ctrl;
      step_d  = '0;
      last_d  = !dec_multi;
    end
  end

  // Handshake outputs; mid-burst beats block new requests
  always_comb begin
    OutValid = 1'b0;
    InReady  = 1'b1;
    case (state_q)
      SINGLE: begin
        OutValid = 1'b1;
        InReady  = OutReady;
      end
      MULTI: begin
        OutValid = 1'b1;
        InReady  = last_q && OutReady;
      end
      default: begin
        OutValid = 1'b0;
        InReady  = 1'b1;
      end
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky flag set when an illegal funct is accepted, cleared only by reset
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      illegal_q <= 1'b0;
    end else if (load && dec_illegal) begin
      illegal_q <= 1'b1;
    end
  end

  assign IllegalOp = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = dec_illegal;
  assign IllegalOp      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed table, corner sequences, random traffic vs. a beat-queue model.
module tb_alu_ctrl_seq;

  localparam int unsigned MB = 4;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       InValid;
  logic       InReady;
  logic [3:0] ALUop;
  logic [5:0] FuncCode;
  logic       OutValid;
  logic       OutReady;
  logic [3:0] ALUCtrl;
  logic [1:0] Step;
  logic       Last;
  logic       IllegalOp;

  alu_ctrl_seq #(
    .OP_W       (4),
    .FUNC_W     (6),
    .MULA_BEATS (MB),
    .STEP_W     (2)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .InValid   (InValid),
    .InReady   (InReady),
    .ALUop     (ALUop),
    .FuncCode  (FuncCode),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .ALUCtrl   (ALUCtrl),
    .Step      (Step),
    .Last      (Last),
    .IllegalOp (IllegalOp)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0] ctrl;
    logic [1:0] step;
    logic       last;
  } beat_t;

  typedef struct {
    logic [3:0] op;
    logic [5:0] fc;
    logic [3:0] ctrl;
    logic       multi;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  beat_t      exp_q[$];
  logic       ill_m = 1'b0;
  logic [3:0] rtab[logic [5:0]];
  logic [5:0] legal_f[$];
  vec_t       tab[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference: every accepted request expands into its list of expected beats
  task automatic model_push(input logic [3:0] op, input logic [5:0] fc);
    logic [3:0] c;
    logic       ill;
    int         nb;
    ill = 1'b0;
    if (op == 4'hF) begin
      if (rtab.exists(fc)) c = rtab[fc];
      else begin
        c   = 4'h2;
        ill = 1'b1;
      end
    end else begin
      c = op;
    end
    nb = (c == 4'h5) ? int'(MB) : 1;
    for (int k = 0; k < nb; k++) exp_q.push_back('{ctrl: c, step: 2'(k), last: (k == nb - 1)});
`ifdef ILLEGAL_TRAP_EN
    if (ill) ill_m = 1'b1;
`endif
  endtask

  // One clock: drive at negedge, check outputs against the model, update the model
  task automatic cycle(input logic iv, input logic [3:0] op, input logic [5:0] fc,
                       input logic ordy, output logic acc);
    logic  exp_ir;
    beat_t f;
    @(negedge Clk);
    InValid  = iv;
    ALUop    = op;
    FuncCode = fc;
    OutReady = ordy;
    #1;
    chk("out_valid", 32'(OutValid), 32'(exp_q.size() != 0));
    exp_ir = 1'b1;
    if (exp_q.size() != 0) begin
      f      = exp_q[0];
      exp_ir = f.last ? ordy : 1'b0;
      chk("alu_ctrl", 32'(ALUCtrl), 32'(f.ctrl));
      chk("step", 32'(Step), 32'(f.step));
      chk("last", 32'(Last), 32'(f.last));
    end
    chk("in_ready", 32'(InReady), 32'(exp_ir));
    chk("illegal_op", 32'(IllegalOp), 32'(ill_m));
    if (OutValid && OutReady && exp_q.size() != 0) void'(exp_q.pop_front());
    acc = iv && InReady;
    if (acc) model_push(op, fc);
  endtask

  task automatic idle(input logic ordy);
    logic a;
    cycle(1'b0, 4'h0, 6'h00, ordy, a);
  endtask

  task automatic send(input logic [3:0] op, input logic [5:0] fc, input logic ordy);
    logic a;
    int   n;
    a = 1'b0;
    n = 0;
    while (!a && n < 20) begin
      cycle(1'b1, op, fc, ordy, a);
      n++;
    end
    chk("send_accept", 32'(a), 32'd1);
  endtask

  // Hold reset across a clock edge, clear the model, check reset values
  task automatic do_reset();
    Reset_n = 1'b0;
    exp_q.delete();
    ill_m = 1'b0;
    #2;
    chk("rst_out_valid", 32'(OutValid), 32'd0);
    chk("rst_step", 32'(Step), 32'd0);
    chk("rst_in_ready", 32'(InReady), 32'd1);
    @(posedge Clk);
    #1;
    chk("rst_alu_ctrl", 32'(ALUCtrl), 32'd0);
    chk("rst_last", 32'(Last), 32'd0);
    chk("rst_illegal", 32'(IllegalOp), 32'd0);
    Reset_n = 1'b1;
  endtask

  initial begin
    logic [5:0] fx;
    logic [3:0] rop;
    logic [5:0] rfc;
    logic       a;
    int         r;
    fx = 'x;

    rtab[6'b000000] = 4'b0011; rtab[6'b000010] = 4'b0100; rtab[6'b000011] = 4'b1101;
    rtab[6'b100000] = 4'b0010; rtab[6'b100001] = 4'b1000; rtab[6'b100010] = 4'b0110;
    rtab[6'b100011] = 4'b1001; rtab[6'b100100] = 4'b0000; rtab[6'b100101] = 4'b0001;
    rtab[6'b100110] = 4'b1010; rtab[6'b100111] = 4'b1100; rtab[6'b101010] = 4'b0111;
    rtab[6'b101011] = 4'b1011; rtab[6'b111000] = 4'b0101;
    foreach (rtab[k]) legal_f.push_back(k);

    tab.push_back('{4'hF, 6'b000000, 4'b0011, 1'b0});
    tab.push_back('{4'hF, 6'b000010, 4'b0100, 1'b0});
    tab.push_back('{4'hF, 6'b000011, 4'b1101, 1'b0});
    tab.push_back('{4'hF, 6'b100000, 4'b0010, 1'b0});
    tab.push_back('{4'hF, 6'b100001, 4'b1000, 1'b0});
    tab.push_back('{4'hF, 6'b100010, 4'b0110, 1'b0});
    tab.push_back('{4'hF, 6'b100011, 4'b1001, 1'b0});
    tab.push_back('{4'hF, 6'b100100, 4'b0000, 1'b0});
    tab.push_back('{4'hF, 6'b100101, 4'b0001, 1'b0});
    tab.push_back('{4'hF, 6'b100110, 4'b1010, 1'b0});
    tab.push_back('{4'hF, 6'b100111, 4'b1100, 1'b0});
    tab.push_back('{4'hF, 6'b101010, 4'b0111, 1'b0});
    tab.push_back('{4'hF, 6'b101011, 4'b1011, 1'b0});
    tab.push_back('{4'hF, 6'b111000, 4'b0101, 1'b1});
    tab.push_back('{4'b0000, fx, 4'b0000, 1'b0});
    tab.push_back('{4'b0001, fx, 4'b0001, 1'b0});
    tab.push_back('{4'b0010, fx, 4'b0010, 1'b0});
    tab.push_back('{4'b0110, fx, 4'b0110, 1'b0});
    tab.push_back('{4'b0111, fx, 4'b0111, 1'b0});
    tab.push_back('{4'b1000, fx, 4'b1000, 1'b0});
    tab.push_back('{4'b1001, fx, 4'b1001, 1'b0});
    tab.push_back('{4'b1010, fx, 4'b1010, 1'b0});
    tab.push_back('{4'b1011, fx, 4'b1011, 1'b0});
    tab.push_back('{4'b1100, fx, 4'b1100, 1'b0});
    tab.push_back('{4'b1110, fx, 4'b1110, 1'b0});
    tab.push_back('{4'b0101, fx, 4'b0101, 1'b1});

    InValid  = 1'b0;
    ALUop    = 4'h0;
    FuncCode = 6'h00;
    OutReady = 1'b0;
    Reset_n  = 1'b0;
    @(negedge Clk);
    do_reset();

    // Directed decode table, OutReady held high
    foreach (tab[i]) begin
      send(tab[i].op, tab[i].fc, 1'b1);
      idle(1'b1);
      chk("tab_ctrl", 32'(ALUCtrl), 32'(tab[i].ctrl));
      chk("tab_last", 32'(Last), 32'(!tab[i].multi));
      chk("tab_step", 32'(Step), 32'd0);
      if (tab[i].multi) repeat (MB - 1) idle(1'b1);
    end
    idle(1'b1);

    // Back-to-back ADD, SUB, OR
    send(4'hF, 6'b100000, 1'b1);
    cycle(1'b1, 4'hF, 6'b100010, 1'b1, a);
    chk("b2b_add", 32'(ALUCtrl), 32'h2);
    chk("b2b_ready1", 32'(InReady), 32'd1);
    cycle(1'b1, 4'hF, 6'b100101, 1'b1, a);
    chk("b2b_sub", 32'(ALUCtrl), 32'h6);
    chk("b2b_ready2", 32'(InReady), 32'd1);
    idle(1'b1);
    chk("b2b_or", 32'(ALUCtrl), 32'h1);
    chk("b2b_valid", 32'(OutValid), 32'd1);
    idle(1'b1);

    // MULA burst at full rate
    send(4'hF, 6'b111000, 1'b1);
    for (int i = 0; i < int'(MB); i++) begin
      idle(1'b1);
      chk("mula_ctrl", 32'(ALUCtrl), 32'h5);
      chk("mula_step", 32'(Step), 32'(i));
      chk("mula_last", 32'(Last), 32'(i == int'(MB) - 1));
      chk("mula_in_ready", 32'(InReady), 32'(i == int'(MB) - 1));
    end
    idle(1'b1);

    // MULA stalled for three cycles at Step=1
    send(4'hF, 6'b111000, 1'b1);
    idle(1'b1);
    repeat (3) begin
      idle(1'b0);
      chk("stall_step", 32'(Step), 32'd1);
      chk("stall_valid", 32'(OutValid), 32'd1);
    end
    for (int i = 1; i < int'(MB); i++) begin
      idle(1'b1);
      chk("resume_step", 32'(Step), 32'(i));
    end
    idle(1'b1);

    // Reset mid-burst at Step=2, then a normal ADD
    send(4'hF, 6'b111000, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("pre_abort_step", 32'(Step), 32'd2);
    do_reset();
    send(4'hF, 6'b100000, 1'b1);
    idle(1'b1);
    chk("post_abort_add", 32'(ALUCtrl), 32'h2);
    chk("post_abort_last", 32'(Last), 32'd1);
    idle(1'b1);

    // Random traffic against the beat-queue model
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) begin
        rop = 4'hF;
        rfc = (r == 0) ? 6'($urandom) : legal_f[$urandom_range(0, legal_f.size() - 1)];
      end else if (r == 6) begin
        rop = 4'h5;
        rfc = 6'($urandom);
      end else begin
        rop = 4'($urandom_range(0, 14));
        rfc = 6'($urandom);
      end
      cycle(1'($urandom), rop, rfc, ($urandom_range(0, 3) != 0), a);
    end
    repeat (12) idle(1'b1);

    // Illegal funct: decodes as ADD; flag sticky only with the trap feature
    do_reset();
    send(4'hF, 6'b111111, 1'b1);
    idle(1'b1);
    chk("illegal_ctrl", 32'(ALUCtrl), 32'h2);
    chk("illegal_last", 32'(Last), 32'd1);
`ifdef ILLEGAL_TRAP_EN
    chk("illegal_set", 32'(IllegalOp), 32'd1);
`else
    chk("illegal_set", 32'(IllegalOp), 32'd0);
`endif
    send(4'hF, 6'b100010, 1'b1);
    repeat (3) idle(1'b1);
`ifdef ILLEGAL_TRAP_EN
    chk("illegal_sticky", 32'(IllegalOp), 32'd1);
`else
    chk("illegal_sticky", 32'(IllegalOp), 32'd0);
`endif
    do_reset();
    idle(1'b1);
    chk("illegal_cleared", 32'(IllegalOp), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
